// File: rtl/mem_stage_lsu_if.sv
// Data-memory port of the MEM-stage LSU: req/gnt request phase, rvalid/rdata response phase.
interface mem_stage_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_be,
        input  dmem_gnt,
        input  dmem_rvalid,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_be,
        output dmem_gnt,
        output dmem_rvalid,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one outstanding data-memory access, stalls EX/MEM until it completes.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and flag misalign_m.
module mem_stage_lsu #(
    parameter int unsigned RSP_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            pc_m,
    input  logic [31:0]            alu_m,
    input  logic [31:0]            rs2_m,
    input  logic [31:0]            inst_m,
    mem_stage_lsu_if.master        dmem,
    output logic                   stall_m,
    output logic [31:0]            pc_w,
    output logic [31:0]            alu_w,
    output logic [31:0]            mem_w,
    output logic [31:0]            inst_w,
    output logic                   bus_err,
    output logic                   misalign_m
);

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [31:0] cnt_q, cnt_d;
    logic        bus_err_q, bus_err_d;
    logic        misalign_q, misalign_d;

    logic [2:0]  funct3;
    logic        is_load, is_store, mem_op, misaligned, timeout_hit;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // ---------------- decode ----------------
    assign funct3   = inst_m[14:12];
    assign is_load  = (inst_m[6:0] == OpLoad) &&
                      (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign is_store = (inst_m[6:0] == OpStore) &&
                      (funct3 inside {3'b000, 3'b001, 3'b010});
    // Held low in reset so no request or stall leaks out while rst is asserted.
    assign mem_op   = rst && (is_load || is_store);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((funct3[1:0] == 2'b10) && (alu_m[1:0] != 2'b00)) ||
                        ((funct3[1:0] == 2'b01) && alu_m[0]);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        be    = 4'b0000;
        wdata = rs2_m;
        unique case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << alu_m[1:0];
                wdata = {4{rs2_m[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << {alu_m[1], 1'b0};
                wdata = {2{rs2_m[15:0]}};
            end
            2'b10: begin
                be    = 4'b1111;
                wdata = rs2_m;
            end
            default: begin
                be    = 4'b0000;
                wdata = rs2_m;
            end
        endcase
    end

    assign timeout_hit = (RSP_TIMEOUT != 0) && ((cnt_q + 32'd1) == RSP_TIMEOUT);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (mem_op) begin
                    if (misaligned) begin
                        state_d = StDone;
                    end else if (dmem.dmem_gnt) begin
                        state_d = is_load ? StWait : StDone;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (dmem.dmem_gnt) begin
                    state_d = is_load ? StWait : StDone;
                end
            end
            StWait: begin
                if (dmem.dmem_rvalid || timeout_hit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        dmem.dmem_req = 1'b0;
        stall_m       = 1'b0;
        unique case (state_q)
            StIdle: begin
                dmem.dmem_req = mem_op && !misaligned;
                stall_m       = mem_op;
            end
            StReq: begin
                dmem.dmem_req = 1'b1;
                stall_m       = 1'b1;
            end
            StWait: begin
                stall_m = 1'b1;
            end
            StDone: begin
                stall_m = 1'b0;
            end
            default: begin
                dmem.dmem_req = 1'b0;
                stall_m       = 1'b0;
            end
        endcase
    end

    assign dmem.dmem_we    = is_store;
    assign dmem.dmem_addr  = {alu_m[31:2], 2'b00};
    assign dmem.dmem_wdata = wdata;
    assign dmem.dmem_be    = be;

    // ---------------- response capture / watchdog ----------------
    always_comb begin
        data_d     = data_q;
        cnt_d      = 32'd0;
        bus_err_d  = 1'b0;
        misalign_d = 1'b0;
        if (state_q == StWait) begin
            cnt_d = cnt_q + 32'd1;
            if (dmem.dmem_rvalid) begin
                data_d = dmem.dmem_rdata;
            end else if (timeout_hit) begin
                data_d    = 32'd0;
                bus_err_d = 1'b1;
            end
        end else if ((state_q == StIdle) && mem_op && misaligned) begin
            data_d     = 32'd0;
            misalign_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q     <= 32'd0;
            cnt_q      <= 32'd0;
            bus_err_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            bus_err_q  <= bus_err_d;
            misalign_q <= misalign_d;
        end
    end

    // ---------------- load extraction ----------------
    assign ld_byte = data_q[{alu_m[1:0], 3'b000} +: 8];
    assign ld_half = data_q[{alu_m[1], 4'b0000} +: 16];

    always_comb begin
        ld_ext = 32'd0;
        unique case (funct3)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_ext = data_q;
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = 32'd0;
        endcase
    end

    // EX/MEM still holds the access instruction during DONE, so inst_m decodes it here.
    assign mem_w      = ((state_q == StDone) && is_load) ? ld_ext : 32'd0;
    assign bus_err    = bus_err_q;
    assign misalign_m = misalign_q;

    assign pc_w   = pc_m;
    assign alu_w  = alu_m;
    assign inst_w = inst_m;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomised bench for mem_stage_lsu: directed corner cases plus a reference model of the access rules.
module tb_mem_stage_lsu;

    localparam int unsigned TMO      = 4;
    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_m, alu_m, rs2_m, inst_m;
    logic        stall_m, bus_err, misalign_m;
    logic [31:0] pc_w, alu_w, mem_w, inst_w;

    mem_stage_lsu_if dmem ();

    mem_stage_lsu #(.RSP_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_m       (pc_m),
        .alu_m      (alu_m),
        .rs2_m      (rs2_m),
        .inst_m     (inst_m),
        .dmem       (dmem),
        .stall_m    (stall_m),
        .pc_w       (pc_w),
        .alu_w      (alu_w),
        .mem_w      (mem_w),
        .inst_w     (inst_w),
        .bus_err    (bus_err),
        .misalign_m (misalign_m)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] mk_inst(input logic [6:0] op, input logic [2:0] f3);
        logic [31:0] r;
        r        = $urandom;
        r[6:0]   = op;
        r[14:12] = f3;
        return r;
    endfunction

    // Reference: pick the addressed byte/half from the returned word, then extend.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    task automatic do_op(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] rdata_in, input int gdel, input int rdel);
        logic [2:0]  f3;
        logic        ld, st, mis, to;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_mw, pc;
        f3  = inst[14:12];
        ld  = (inst[6:0] == OP_LOAD) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        st  = (inst[6:0] == OP_STORE) && (f3 inside {3'd0, 3'd1, 3'd2});
        mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (f3[1:0] == 2'd2 && addr[1:0] != 2'd0) || (f3[1:0] == 2'd1 && addr[0]);
`endif
        case (f3[1:0])
            2'd0:    begin exp_be = 4'b0001 << addr[1:0];       exp_wd = rs2[7:0] * 32'h0101_0101;  end
            2'd1:    begin exp_be = 4'b0011 << (2 * addr[1]);   exp_wd = rs2[15:0] * 32'h0001_0001; end
            default: begin exp_be = 4'b1111;                    exp_wd = rs2;                       end
        endcase
        pc = $urandom;

        @(negedge clk);
        pc_m = pc; alu_m = addr; rs2_m = rs2; inst_m = inst;
        dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0;
        if (!(ld || st)) begin
            #1;
            check_eq("nonmem_stall", stall_m, 0);
            check_eq("nonmem_req", dmem.dmem_req, 0);
            check_eq("nonmem_mem_w", mem_w, 0);
            check_eq("pc_pass", pc_w, pc);
            return;
        end
        if (mis) begin
            #1;
            check_eq("mis_req", dmem.dmem_req, 0);
            @(negedge clk);
            #1;
            check_eq("mis_flag", misalign_m, 1);
            check_eq("mis_stall", stall_m, 0);
            check_eq("mis_mem_w", mem_w, 0);
            return;
        end
        for (int i = 0; i <= gdel; i++) begin
            if (i > 0) @(negedge clk);
            dmem.dmem_gnt    = (i == gdel);
            dmem.dmem_rvalid = 1'($urandom_range(0, 1));
            dmem.dmem_rdata  = $urandom;
            #1;
            check_eq("req", dmem.dmem_req, 1);
            check_eq("req_stall", stall_m, 1);
            check_eq("addr", dmem.dmem_addr, {addr[31:2], 2'b00});
            check_eq("be", 32'(dmem.dmem_be), 32'(exp_be));
            check_eq("we", dmem.dmem_we, st);
            if (st) check_eq("wdata", dmem.dmem_wdata, exp_wd);
        end
        to = 1'b0;
        if (ld) begin
            to = (rdel >= TMO);
            for (int j = 0; j < TMO; j++) begin
                @(negedge clk);
                dmem.dmem_gnt    = 1'($urandom_range(0, 1));
                dmem.dmem_rvalid = (j == rdel);
                dmem.dmem_rdata  = (j == rdel) ? rdata_in : $urandom;
                #1;
                check_eq("wait_stall", stall_m, 1);
                check_eq("wait_req", dmem.dmem_req, 0);
                if (j == rdel) break;
            end
        end
        exp_mw = (ld && !to) ? ref_load(f3, addr, rdata_in) : 32'd0;
        @(negedge clk);
        dmem.dmem_gnt    = 1'($urandom_range(0, 1));
        dmem.dmem_rvalid = 1'($urandom_range(0, 1));
        dmem.dmem_rdata  = $urandom;
        #1;
        check_eq("done_stall", stall_m, 0);
        check_eq("done_req", dmem.dmem_req, 0);
        check_eq("mem_w", mem_w, exp_mw);
        check_eq("bus_err", bus_err, ld && to);
        check_eq("misalign", misalign_m, 0);
        check_eq("inst_pass", inst_w, inst);
    endtask

    initial begin
        logic [2:0] f3;
        logic [6:0] op;
        rst = 1'b0;
        pc_m = 0; alu_m = 32'h100; rs2_m = 0;
        inst_m = mk_inst(OP_LOAD, 3'd2);
        dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = 0;
        #1;
        check_eq("rst_req", dmem.dmem_req, 0);
        check_eq("rst_stall", stall_m, 0);
        check_eq("rst_bus_err", bus_err, 0);
        check_eq("rst_misalign", misalign_m, 0);
        check_eq("rst_mem_w", mem_w, 0);
        repeat (2) @(negedge clk);
        inst_m = 32'h0000_0013;
        rst = 1'b1;

        do_op(mk_inst(OP_LOAD, 3'd2), 32'h100, 0, 32'hDEAD_BEEF, 0, 0);
        do_op(mk_inst(OP_STORE, 3'd0), 32'h203, 32'h0000_00A5, 0, 3, 0);
        do_op(mk_inst(OP_LOAD, 3'd0), 32'h101, 0, 32'h0000_8000, 0, 0);
        do_op(mk_inst(OP_LOAD, 3'd4), 32'h101, 0, 32'h0000_8000, 1, 2);
        do_op(mk_inst(OP_LOAD, 3'd1), 32'h102, 0, 32'h8000_0000, 0, 1);
        do_op(mk_inst(OP_LOAD, 3'd2), 32'h104, 0, 32'h1234_5678, 0, 10);
        do_op(mk_inst(OP_LOAD, 3'd2), 32'h102, 0, 32'hCAFE_F00D, 2, 0);
        do_op(mk_inst(OP_STORE, 3'd1), 32'h302, 32'h0000_BEEF, 0, 0, 0);

        // Reset abandons an access sitting in WAIT; a late rvalid must be ignored.
        @(negedge clk);
        inst_m = mk_inst(OP_LOAD, 3'd2); alu_m = 32'h40;
        dmem.dmem_gnt = 1'b1; dmem.dmem_rvalid = 1'b0;
        @(negedge clk);
        dmem.dmem_gnt = 1'b0;
        #1;
        check_eq("rw_wait_stall", stall_m, 1);
        rst = 1'b0;
        #1;
        check_eq("rw_req", dmem.dmem_req, 0);
        check_eq("rw_stall", stall_m, 0);
        inst_m = 32'h0000_0013;
        @(negedge clk);
        rst = 1'b1;
        dmem.dmem_rvalid = 1'b1; dmem.dmem_rdata = 32'hFFFF_FFFF;
        #1;
        check_eq("rw_idle_stall", stall_m, 0);
        @(negedge clk);
        dmem.dmem_rvalid = 1'b0;
        #1;
        check_eq("rw_idle_mem_w", mem_w, 0);
        check_eq("rw_idle_bus_err", bus_err, 0);
        check_eq("rw_idle_req", dmem.dmem_req, 0);

        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 2))
                0: begin
                    case ($urandom_range(0, 4))
                        0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
                    endcase
                    do_op(mk_inst(OP_LOAD, f3), $urandom, $urandom, $urandom,
                          $urandom_range(0, 3), $urandom_range(0, 5));
                end
                1: begin
                    f3 = 3'($urandom_range(0, 2));
                    do_op(mk_inst(OP_STORE, f3), $urandom, $urandom, $urandom,
                          $urandom_range(0, 3), 0);
                end
                default: begin
                    if ($urandom_range(0, 1) == 0) begin
                        op = 7'($urandom);
                        if (op == OP_LOAD || op == OP_STORE) op = 7'b0010011;
                        do_op(mk_inst(op, 3'($urandom)), $urandom, $urandom, 0, 0, 0);
                    end else begin
                        f3 = 3'($urandom_range(6, 7));
                        do_op(mk_inst(OP_LOAD, f3), $urandom, $urandom, 0, 0, 0);
                    end
                end
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

endmodule
